// File: rtl/brn_resolve_pkg.sv
// rtl/brn_resolve_pkg.sv - shared encodings, BHT counter type and helpers for branch resolution
package brn_resolve_pkg;

  // funct3 branch condition encodings
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef logic [1:0] bht_cnt_t;

  // weakly not-taken
  localparam bht_cnt_t BHT_INIT = 2'b01;

  // 2-bit saturating up/down step
  function automatic bht_cnt_t bht_sat_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - 2-bit saturating branch history table, comb read, sync write, async reset
module bht_2bit #(
  parameter int                        IDX_W = 6,
  parameter brn_resolve_pkg::bht_cnt_t INIT  = brn_resolve_pkg::BHT_INIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IDX_W-1:0]                rd_idx_i,
  output brn_resolve_pkg::bht_cnt_t       rd_cnt_o,
  input  logic                            wr_en_i,
  input  logic [IDX_W-1:0]                wr_idx_i,
  input  logic                            wr_taken_i
);
  import brn_resolve_pkg::*;

  localparam int ENTRIES = 1 << IDX_W;

  bht_cnt_t cnt_q [ENTRIES];
  bht_cnt_t cnt_d [ENTRIES];

  // read returns the stored value; a same-cycle write is not bypassed
  always_comb begin
    rd_cnt_o = cnt_q[rd_idx_i];
  end

  // next-state: at most one entry trained per cycle
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (wr_en_i) begin
      cnt_d[wr_idx_i] = bht_sat_update(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

  // counter array; reset wins over any in-flight update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= INIT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/brn_resolve_unit.sv
// rtl/brn_resolve_unit.sv - EX-stage branch resolution, redirect/flush and BHT training (optional BRN_RESOLVE_STATS_EN)
module brn_resolve_unit #(
  parameter int                        BHT_IDX_W = 6,
  parameter brn_resolve_pkg::bht_cnt_t BHT_INIT  = brn_resolve_pkg::BHT_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_ex_i,
  input  logic [6:0]  op_ex_i,
  input  logic [2:0]  funct3_ex_i,
  input  logic        is_b_type_ex_i,
  input  logic        jump_ex_i,
  input  logic [31:0] r_data_p1_ex_i,
  input  logic [31:0] r_data_p2_ex_i,
  input  logic [31:0] sext_imm_ex_i,
  input  logic [31:0] curr_pc_ex_i,
  input  logic [31:0] next_seq_pc_ex_i,
  input  logic [31:0] next_brn_pc_ex_i,
  input  logic [31:0] next_pred_pc_ex_i,
  input  logic        brn_pred_ex_i,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_taken_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        clr_ex_o,
  output logic        brn_taken_o
`ifdef BRN_RESOLVE_STATS_EN
  ,
  output logic [31:0] stat_brn_cnt_o,
  output logic [31:0] stat_mispred_cnt_o
`endif
);
  import brn_resolve_pkg::*;

  logic        ctl;
  logic        cond;
  logic        taken;
  logic        is_jalr;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic [31:0] actual_pc;
  logic        mispred;
  logic        bht_wr_en;
  bht_cnt_t    lookup_cnt;

  // direction prediction is a PC-only check; the predicted bit and high PC bits are not needed here
  logic unused_bits;
  assign unused_bits = ^{brn_pred_ex_i, curr_pc_ex_i[31:BHT_IDX_W+2], curr_pc_ex_i[1:0],
                         lookup_pc_i[31:BHT_IDX_W+2], lookup_pc_i[1:0], lookup_cnt[0]};

  // evaluate condition, target and mispredict for the instruction in EX
  always_comb begin
    ctl       = 1'b0;
    cond      = 1'b0;
    taken     = 1'b0;
    is_jalr   = 1'b0;
    jalr_sum  = 32'h0;
    target    = 32'h0;
    actual_pc = 32'h0;
    mispred   = 1'b0;
    bht_wr_en = 1'b0;

    ctl = valid_ex_i & (is_b_type_ex_i | jump_ex_i);

    case (funct3_ex_i)
      BR_EQ:   cond = (r_data_p1_ex_i == r_data_p2_ex_i);
      BR_NE:   cond = (r_data_p1_ex_i != r_data_p2_ex_i);
      BR_LT:   cond = ($signed(r_data_p1_ex_i) <  $signed(r_data_p2_ex_i));
      BR_GE:   cond = ($signed(r_data_p1_ex_i) >= $signed(r_data_p2_ex_i));
      BR_LTU:  cond = (r_data_p1_ex_i <  r_data_p2_ex_i);
      BR_GEU:  cond = (r_data_p1_ex_i >= r_data_p2_ex_i);
      default: cond = 1'b0;
    endcase

    taken    = jump_ex_i | (is_b_type_ex_i & cond);
    is_jalr  = jump_ex_i & (op_ex_i == OP_JALR);
    jalr_sum = r_data_p1_ex_i + sext_imm_ex_i;
    target   = is_jalr ? (jalr_sum & 32'hFFFF_FFFE) : next_brn_pc_ex_i;

    // non-control instructions fall through, so a stale BTB hit also redirects
    actual_pc = taken ? target : next_seq_pc_ex_i;
    mispred   = valid_ex_i & (actual_pc != next_pred_pc_ex_i);
    bht_wr_en = valid_ex_i & is_b_type_ex_i;
  end

  // drive redirect and squash outputs; the EX instruction itself keeps going
  always_comb begin
    redirect_o    = mispred;
    redirect_pc_o = valid_ex_i ? actual_pc : 32'h0;
    flush_if_o    = mispred;
    flush_id_o    = mispred;
    clr_ex_o      = mispred;
    brn_taken_o   = valid_ex_i & taken;
    pred_taken_o  = lookup_cnt[1];
  end

  bht_2bit #(
    .IDX_W (BHT_IDX_W),
    .INIT  (BHT_INIT)
  ) u_bht (
    .clk        (clk),
    .rst        (reset),
    .rd_idx_i   (lookup_pc_i[BHT_IDX_W+1:2]),
    .rd_cnt_o   (lookup_cnt),
    .wr_en_i    (bht_wr_en),
    .wr_idx_i   (curr_pc_ex_i[BHT_IDX_W+1:2]),
    .wr_taken_i (taken)
  );

`ifdef BRN_RESOLVE_STATS_EN
  logic [31:0] stat_brn_cnt_q;
  logic [31:0] stat_brn_cnt_d;
  logic [31:0] stat_mispred_cnt_q;
  logic [31:0] stat_mispred_cnt_d;

  // saturating event counters
  always_comb begin
    stat_brn_cnt_d     = stat_brn_cnt_q;
    stat_mispred_cnt_d = stat_mispred_cnt_q;
    if (ctl && (stat_brn_cnt_q != 32'hFFFF_FFFF)) begin
      stat_brn_cnt_d = stat_brn_cnt_q + 32'd1;
    end
    if (mispred && (stat_mispred_cnt_q != 32'hFFFF_FFFF)) begin
      stat_mispred_cnt_d = stat_mispred_cnt_q + 32'd1;
    end
  end

  // stats registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_brn_cnt_q     <= 32'h0;
      stat_mispred_cnt_q <= 32'h0;
    end else begin
      stat_brn_cnt_q     <= stat_brn_cnt_d;
      stat_mispred_cnt_q <= stat_mispred_cnt_d;
    end
  end

  assign stat_brn_cnt_o     = stat_brn_cnt_q;
  assign stat_mispred_cnt_o = stat_mispred_cnt_q;
`else
  logic unused_ctl;
  assign unused_ctl = ctl;
`endif

endmodule

// File: tb/tb_brn_resolve_unit.sv
// tb/tb_brn_resolve_unit.sv - directed scoreboard bench for brn_resolve_unit
module tb_brn_resolve_unit;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex_i;
  logic [6:0]  op_ex_i;
  logic [2:0]  funct3_ex_i;
  logic        is_b_type_ex_i;
  logic        jump_ex_i;
  logic [31:0] r_data_p1_ex_i, r_data_p2_ex_i, sext_imm_ex_i;
  logic [31:0] curr_pc_ex_i, next_seq_pc_ex_i, next_brn_pc_ex_i, next_pred_pc_ex_i;
  logic        brn_pred_ex_i;
  logic [31:0] lookup_pc_i;
  logic        pred_taken_o, redirect_o, flush_if_o, flush_id_o, clr_ex_o, brn_taken_o;
  logic [31:0] redirect_pc_o;
`ifdef BRN_RESOLVE_STATS_EN
  logic [31:0] stat_brn_cnt_o, stat_mispred_cnt_o;
`endif

  brn_resolve_unit dut (
    .clk               (clk),
    .reset             (reset),
    .valid_ex_i        (valid_ex_i),
    .op_ex_i           (op_ex_i),
    .funct3_ex_i       (funct3_ex_i),
    .is_b_type_ex_i    (is_b_type_ex_i),
    .jump_ex_i         (jump_ex_i),
    .r_data_p1_ex_i    (r_data_p1_ex_i),
    .r_data_p2_ex_i    (r_data_p2_ex_i),
    .sext_imm_ex_i     (sext_imm_ex_i),
    .curr_pc_ex_i      (curr_pc_ex_i),
    .next_seq_pc_ex_i  (next_seq_pc_ex_i),
    .next_brn_pc_ex_i  (next_brn_pc_ex_i),
    .next_pred_pc_ex_i (next_pred_pc_ex_i),
    .brn_pred_ex_i     (brn_pred_ex_i),
    .lookup_pc_i       (lookup_pc_i),
    .pred_taken_o      (pred_taken_o),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o),
    .flush_if_o        (flush_if_o),
    .flush_id_o        (flush_id_o),
    .clr_ex_o          (clr_ex_o),
    .brn_taken_o       (brn_taken_o)
`ifdef BRN_RESOLVE_STATS_EN
    ,
    .stat_brn_cnt_o     (stat_brn_cnt_o),
    .stat_mispred_cnt_o (stat_mispred_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        redir;
    logic [31:0] rpc;
    logic        taken;
    logic        pred;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] bht_m [64];
  int         checks   = 0;
  int         failures = 0;
  int         n_ctl    = 0;
  int         n_mis    = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    n_ctl = 0;
    n_mis = 0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    cmp($sformatf("%s.bht[%0d]", tag, i), {30'h0, dut.u_bht.cnt_q[i]}, {30'h0, bht_m[i]});
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    cmp({e.tag, ".redirect"}, {31'h0, redirect_o}, {31'h0, e.redir});
    cmp({e.tag, ".redirect_pc"}, redirect_pc_o, e.rpc);
    cmp({e.tag, ".flushes"}, {29'h0, flush_if_o, flush_id_o, clr_ex_o}, {29'h0, {3{e.redir}}});
    cmp({e.tag, ".taken"}, {31'h0, brn_taken_o}, {31'h0, e.taken});
    cmp({e.tag, ".pred_taken"}, {31'h0, pred_taken_o}, {31'h0, e.pred});
  endtask

  // one EX-stage instruction: drive at negedge, check mid-cycle, let the posedge train, then idle
  task automatic step(input string tag, input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic isb, input logic jmp, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] imm, input logic [31:0] cpc, input logic [31:0] seq,
                      input logic [31:0] brn, input logic [31:0] pred, input logic [31:0] lpc,
                      input logic e_redir, input logic [31:0] e_rpc, input logic e_taken);
    exp_t e;
    @(negedge clk);
    valid_ex_i = v; op_ex_i = op; funct3_ex_i = f3; is_b_type_ex_i = isb; jump_ex_i = jmp;
    r_data_p1_ex_i = p1; r_data_p2_ex_i = p2; sext_imm_ex_i = imm;
    curr_pc_ex_i = cpc; next_seq_pc_ex_i = seq; next_brn_pc_ex_i = brn; next_pred_pc_ex_i = pred;
    brn_pred_ex_i = ~e_taken; lookup_pc_i = lpc;
    e.tag = tag; e.redir = e_redir; e.rpc = e_rpc; e.taken = e_taken;
    e.pred = bht_m[idx_of(lpc)][1];
    exp_q.push_back(e);
    #2;
    pop_check();
    if (v && isb) begin
      if (e_taken && bht_m[idx_of(cpc)] != 2'b11) bht_m[idx_of(cpc)] = bht_m[idx_of(cpc)] + 2'b01;
      if (!e_taken && bht_m[idx_of(cpc)] != 2'b00) bht_m[idx_of(cpc)] = bht_m[idx_of(cpc)] - 2'b01;
    end
    if (v && (isb || jmp)) n_ctl++;
    if (e_redir) n_mis++;
    @(posedge clk);
    #1;
    valid_ex_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid_ex_i = 0; op_ex_i = 0; funct3_ex_i = 0; is_b_type_ex_i = 0; jump_ex_i = 0;
    r_data_p1_ex_i = 0; r_data_p2_ex_i = 0; sext_imm_ex_i = 0;
    curr_pc_ex_i = 0; next_seq_pc_ex_i = 0; next_brn_pc_ex_i = 0; next_pred_pc_ex_i = 0;
    brn_pred_ex_i = 0; lookup_pc_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("reset.redirect", {31'h0, redirect_o}, 32'd0);
    cmp("reset.pred_taken", {31'h0, pred_taken_o}, 32'd0);
    chk_cnt("reset", 32'h0000_0100);
    chk_cnt("reset", 32'h0000_00FC);
    reset = 1'b0;

    // BEQ taken, predicted fall-through
    step("beq_taken", 1, OP_BR, 3'b000, 1, 0, 32'd5, 32'd5, 32'h0, 32'h100, 32'h104, 32'h140, 32'h104,
         32'h100, 1, 32'h140, 1);
    chk_cnt("beq_taken", 32'h100);

    // BLTU with all-ones vs 1: not taken, twice to hit the floor
    step("bltu_nt0", 1, OP_BR, 3'b110, 1, 0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h204, 32'h208, 32'h300, 32'h208,
         32'h204, 0, 32'h208, 0);
    chk_cnt("bltu_nt0", 32'h204);
    step("bltu_nt1", 1, OP_BR, 3'b110, 1, 0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h204, 32'h208, 32'h300, 32'h208,
         32'h204, 0, 32'h208, 0);
    chk_cnt("bltu_nt1", 32'h204);

    // JALR with odd sum: bit 0 cleared, branch-target field ignored, BHT untouched
    step("jalr_hit", 1, OP_JALR, 3'b000, 0, 1, 32'h1001, 32'h0, 32'h10, 32'h1000, 32'h1004, 32'hDEAD_0000,
         32'h1010, 32'h1000, 0, 32'h1010, 1);
    step("jalr_miss", 1, OP_JALR, 3'b000, 0, 1, 32'h1001, 32'h0, 32'h10, 32'h1000, 32'h1004, 32'hDEAD_0000,
         32'h1014, 32'h1000, 1, 32'h1010, 1);
    chk_cnt("jalr_miss", 32'h1000);

    // JAL uses the precomputed branch target
    step("jal_hit", 1, OP_JAL, 3'b000, 0, 1, 32'h0, 32'h0, 32'h0, 32'h1F00, 32'h1F04, 32'h2000, 32'h2000,
         32'h1F00, 0, 32'h2000, 1);

    // non-control instruction with a stale predicted PC
    step("btb_alias", 1, OP_ALU, 3'b000, 0, 0, 32'h0, 32'h0, 32'h0, 32'h2C, 32'h30, 32'h80, 32'h80,
         32'h2C, 1, 32'h30, 0);

    // signed compares and a reserved funct3
    step("blt_signed", 1, OP_BR, 3'b100, 1, 0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h410, 32'h414, 32'h500, 32'h414,
         32'h410, 1, 32'h500, 1);
    step("bge_signed", 1, OP_BR, 3'b101, 1, 0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h418, 32'h41C, 32'h500, 32'h500,
         32'h418, 1, 32'h41C, 0);
    step("f3_010", 1, OP_BR, 3'b010, 1, 0, 32'h0, 32'h0, 32'h0, 32'h424, 32'h428, 32'h600, 32'h428,
         32'h424, 0, 32'h428, 0);
    step("bgeu", 1, OP_BR, 3'b111, 1, 0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h430, 32'h434, 32'h600, 32'h600,
         32'h430, 0, 32'h600, 1);
    chk_cnt("bgeu", 32'h430);

    // invalid slot: everything quiet, no training
    step("invalid", 0, OP_BR, 3'b000, 1, 1, 32'd7, 32'd7, 32'h0, 32'h440, 32'h444, 32'h900, 32'h123,
         32'h440, 0, 32'h0, 0);
    chk_cnt("invalid", 32'h440);

    // repeated taken BNE with lookup on the same PC: prediction trails training by one cycle
    for (int k = 0; k < 4; k++) begin
      step($sformatf("bne_sat%0d", k), 1, OP_BR, 3'b001, 1, 0, 32'd1, 32'd2, 32'h0, 32'h320, 32'h324, 32'h380,
           32'h380, 32'h320, 0, 32'h380, 1);
      chk_cnt($sformatf("bne_sat%0d", k), 32'h320);
    end

`ifdef BRN_RESOLVE_STATS_EN
    cmp("stats.brn", stat_brn_cnt_o, n_ctl);
    cmp("stats.mispred", stat_mispred_cnt_o, n_mis);
`endif

    // asynchronous reset in the middle of a training cycle
    @(negedge clk);
    valid_ex_i = 1; op_ex_i = OP_BR; funct3_ex_i = 3'b001; is_b_type_ex_i = 1; jump_ex_i = 0;
    r_data_p1_ex_i = 32'd1; r_data_p2_ex_i = 32'd2;
    curr_pc_ex_i = 32'h320; next_seq_pc_ex_i = 32'h324; next_brn_pc_ex_i = 32'h380; next_pred_pc_ex_i = 32'h380;
    lookup_pc_i = 32'h320;
    #1;
    cmp("pre_rst.pred_taken", {31'h0, pred_taken_o}, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    cmp("mid_rst.pred_taken", {31'h0, pred_taken_o}, 32'd0);
    cmp("mid_rst.taken", {31'h0, brn_taken_o}, 32'd1);
    chk_cnt("mid_rst", 32'h320);
    @(posedge clk);
    #1;
    chk_cnt("rst_edge", 32'h320);
`ifdef BRN_RESOLVE_STATS_EN
    cmp("rst.stats_brn", stat_brn_cnt_o, 32'd0);
`endif
    valid_ex_i = 1'b0;
    reset = 1'b0;
    #1;
    cmp("post_rst.redirect", {31'h0, redirect_o}, 32'd0);
    cmp("post_rst.redirect_pc", redirect_pc_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
